frame_data_reg_bank: RTL and testbench
======================================

Name: frame_data_reg_bank

Overview:
Parametrised, double-buffered bank of frame-data row registers. One instance replaces a column of single-row frame-data registers.
Rows are written into shadow registers over the shared frame-data bus, addressed by RowSelect. They transfer atomically to the active outputs on a commit, so the fabric never sees a half-written frame.
Tracks per-row load status, overwrites and a committed-frame count for the configuration controller.

Parameters:
FrameBitsPerRow, 32, width of one row of frame data
RowSelectWidth, 5, width of RowSelect
NumRows, 6, number of rows held by the bank
FirstRow, 1, RowSelect value mapped to bank row 0; row r responds to FirstRow+r
AutoCommit, 0, 1 = commit automatically when every row has been loaded
CountWidth, 8, width of the committed-frame counter

Ports:
CLK  input  1  clock; all state updates on rising edge
resetn  input  1  asynchronous, active-low reset
FrameData_I  input  FrameBitsPerRow  row data to load
RowSelect  input  RowSelectWidth  target row address
FrameStrobe  input  1  write qualifier; RowSelect/FrameData_I valid when high
Commit  input  1  single-cycle request to transfer shadow to active
FrameData_O  output  NumRows*FrameBitsPerRow  active data; row r at bits [r*FrameBitsPerRow +: FrameBitsPerRow]
RowLoaded  output  NumRows  shadow row r written since last commit
Filling  output  1  high in FILL state
CommitDone  output  1  one-cycle pulse after a commit transfer
Overwrite  output  1  sticky: a shadow row was written twice before commit
FrameCount  output  CountWidth  number of commits performed, wraps

Behaviour:
- Reset (async assert, sync release by the system): shadow and active registers 0, RowLoaded 0, state IDLE, CommitDone 0, Overwrite 0, FrameCount 0. Reset mid-load discards the partial frame.
- Write accept: FrameStrobe=1 and FirstRow <= RowSelect <= FirstRow+NumRows-1.
  - Shadow[RowSelect-FirstRow] <= FrameData_I and its RowLoaded bit set at the same edge.
  - Out-of-range or FrameStrobe=0: no state change.
- Overwrite: an accepted write to a row whose RowLoaded bit is already 1 sets Overwrite. The new data replaces the old. Overwrite clears only on reset.
- FSM states:
  - IDLE: RowLoaded == 0. Goes to FILL on an accepted write.
  - FILL: at least one row loaded. Goes to IDLE on commit.
- Commit trigger at edge k, when either holds:
  - Commit=1 in FILL state;
  - AutoCommit=1 and RowLoaded is all-ones before edge k.
- Commit at edge k:
  - Active rows with RowLoaded=1 take their shadow value; unloaded rows keep their active value.
  - RowLoaded cleared; FrameCount increments (modulo 2^CountWidth).
  - CommitDone=1 for the cycle following edge k.
  - FrameData_O is visible from edge k, so latency is 0 cycles after the sampled request.
- Commit=1 in IDLE: ignored. No count change, no CommitDone.
- Write and commit in the same cycle: the commit uses the pre-edge shadow/RowLoaded. The write lands in shadow and sets its RowLoaded bit after the clear. It belongs to the next frame, and state becomes FILL.
- Shadow contents are not cleared by commit; only RowLoaded is.
- FrameCount wraps from 2^CountWidth-1 to 0 without a flag.

Optional Feature:
FRAME_DATA_REG_PARITY_EN:
- Defined: adds input FrameParity_I (1 bit, even parity over FrameData_I) and output ParityError (sticky, reset 0).
  - A write with mismatched parity is rejected: no shadow or RowLoaded change.
  - ParityError is set.
  - A commit while ParityError=1 still proceeds.
- Undefined: no extra ports; all in-range strobed writes are accepted.

Test Plan:
- Reset then idle 10 cycles -> FrameData_O=0, RowLoaded=0, FrameCount=0, CommitDone never high.
- Defaults; write rows RowSelect=1..6 with 0x11111111..0x66666666, then Commit -> FrameData_O row0=0x11111111 … row5=0x66666666 from the commit edge; CommitDone one cycle; FrameCount=1; RowLoaded=0.
- RowSelect=0 and 7 with FrameStrobe=1, data 0xDEADBEEF -> no RowLoaded change, FSM stays IDLE; following Commit ignored, FrameCount stays 0.
- Row 3 written with 0xAAAA0000, then 0x0000BBBB, commit -> Overwrite=1; active row2 (RowSelect 3) = 0x0000BBBB; other rows unchanged.
- AutoCommit=1: load all 6 rows; on the next cycle write RowSelect=2 with 0x12345678 -> auto commit excludes it; RowLoaded=6'b000010 afterwards; FrameCount=1.
- With FRAME_DATA_REG_PARITY_EN: write with wrong parity -> ParityError=1, RowLoaded unchanged. Async reset asserted mid-FILL -> all outputs 0 immediately.

Source files
------------

// File: rtl/frame_data_reg_bank.sv
// Double-buffered bank of frame-data row registers: rows load into shadow storage and move to the active outputs together on commit.
// Optional build macro FRAME_DATA_REG_PARITY_EN adds even-parity checking of each written row.
module frame_data_reg_bank #(
   parameter int FrameBitsPerRow = 32,
   parameter int RowSelectWidth  = 5,
   parameter int NumRows         = 6,
   parameter int FirstRow        = 1,
   parameter bit AutoCommit      = 1'b0,
   parameter int CountWidth      = 8
) (
   input  logic                               CLK,
   input  logic                               resetn,
   input  logic [FrameBitsPerRow-1:0]         FrameData_I,
   input  logic [RowSelectWidth-1:0]          RowSelect,
   input  logic                               FrameStrobe,
   input  logic                               Commit,
`ifdef FRAME_DATA_REG_PARITY_EN
   input  logic                               FrameParity_I,
   output logic                               ParityError,
`endif
   output logic [NumRows*FrameBitsPerRow-1:0] FrameData_O,
   output logic [NumRows-1:0]                 RowLoaded,
   output logic                               Filling,
   output logic                               CommitDone,
   output logic                               Overwrite,
   output logic [CountWidth-1:0]              FrameCount
);

   localparam int LastRow = FirstRow + NumRows - 1;

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_FILL = 1'b1;

   logic [0:0]                 r_state;
   logic [NumRows-1:0]         r_row_loaded;
   logic                       r_commit_done;
   logic                       r_overwrite;
   logic [CountWidth-1:0]      r_frame_count;
   logic [FrameBitsPerRow-1:0] r_shadow [NumRows];
   logic [FrameBitsPerRow-1:0] r_active [NumRows];

   logic                       w_in_range;
   logic                       w_parity_ok;
   logic                       w_write;
   logic                       w_commit;
   logic [RowSelectWidth-1:0]  w_row_off;
   logic [NumRows-1:0]         w_hit;

   assign w_in_range = (int'(RowSelect) >= FirstRow) && (int'(RowSelect) <= LastRow);
   assign w_row_off  = RowSelect - RowSelectWidth'(FirstRow);

`ifdef FRAME_DATA_REG_PARITY_EN
   logic r_parity_error;

   assign w_parity_ok = ((^FrameData_I) == FrameParity_I);
   assign ParityError = r_parity_error;

   // A strobed, in-range write with bad parity is dropped but flagged.
   always_ff @(posedge CLK or negedge resetn) begin
      if (!resetn) begin
         r_parity_error <= 1'b0;
      end else if (FrameStrobe && w_in_range && !w_parity_ok) begin
         r_parity_error <= 1'b1;
      end
   end
`else
   assign w_parity_ok = 1'b1;
`endif

   assign w_write  = FrameStrobe && w_in_range && w_parity_ok;
   assign w_commit = ((r_state == S_FILL) && Commit) || (AutoCommit && (&r_row_loaded));

   genvar gi;
   generate
      for (gi = 0; gi < NumRows; gi++) begin : g_row
         assign w_hit[gi] = w_write && (w_row_off == RowSelectWidth'(gi));
         assign FrameData_O[gi*FrameBitsPerRow +: FrameBitsPerRow] = r_active[gi];

         always_ff @(posedge CLK or negedge resetn) begin
            if (!resetn) begin
               r_shadow[gi] <= '0;
            end else if (w_hit[gi]) begin
               r_shadow[gi] <= FrameData_I;
            end
         end

         // Unloaded rows keep their previous active value across a commit.
         always_ff @(posedge CLK or negedge resetn) begin
            if (!resetn) begin
               r_active[gi] <= '0;
            end else if (w_commit && r_row_loaded[gi]) begin
               r_active[gi] <= r_shadow[gi];
            end
         end

         // The clear from a commit applies first; a same-cycle write opens the next frame.
         always_ff @(posedge CLK or negedge resetn) begin
            if (!resetn) begin
               r_row_loaded[gi] <= 1'b0;
            end else if (w_hit[gi]) begin
               r_row_loaded[gi] <= 1'b1;
            end else if (w_commit) begin
               r_row_loaded[gi] <= 1'b0;
            end
         end
      end
   endgenerate

   always_ff @(posedge CLK or negedge resetn) begin
      if (!resetn) begin
         r_state <= S_IDLE;
      end else if (w_write) begin
         r_state <= S_FILL;
      end else if (w_commit) begin
         r_state <= S_IDLE;
      end
   end

   always_ff @(posedge CLK or negedge resetn) begin
      if (!resetn) begin
         r_commit_done <= 1'b0;
         r_frame_count <= '0;
         r_overwrite   <= 1'b0;
      end else begin
         r_commit_done <= w_commit;
         if (w_commit) begin
            r_frame_count <= r_frame_count + 1'b1;
         end
         // A write that lands after a same-edge commit starts a fresh frame, so it is no overwrite.
         if ((|(w_hit & r_row_loaded)) && !w_commit) begin
            r_overwrite <= 1'b1;
         end
      end
   end

   assign RowLoaded  = r_row_loaded;
   assign Filling    = (r_state == S_FILL);
   assign CommitDone = r_commit_done;
   assign Overwrite  = r_overwrite;
   assign FrameCount = r_frame_count;

endmodule

// File: tb/tb_frame_data_reg_bank.sv
// Directed bench for frame_data_reg_bank: manual-commit instance plus an AutoCommit instance on shared inputs.
module tb_frame_data_reg_bank;

   logic         CLK = 1'b0;
   logic         resetn = 1'b0;
   logic [31:0]  FrameData_I = '0;
   logic [4:0]   RowSelect = '0;
   logic         FrameStrobe = 1'b0;
   logic         Commit = 1'b0;

   logic [191:0] FrameData_O, ac_FrameData_O;
   logic [5:0]   RowLoaded, ac_RowLoaded;
   logic         Filling, ac_Filling;
   logic         CommitDone, ac_CommitDone;
   logic         Overwrite, ac_Overwrite;
   logic [7:0]   FrameCount, ac_FrameCount;

`ifdef FRAME_DATA_REG_PARITY_EN
   logic par_flip = 1'b0;
   logic FrameParity_I;
   logic ParityError, ac_ParityError;
   assign FrameParity_I = (^FrameData_I) ^ par_flip;
`endif

   int n_cmp = 0;
   int n_err = 0;
   logic [31:0] exp_rows [6];

   always #5 CLK = ~CLK;

   frame_data_reg_bank dut (
      .CLK(CLK), .resetn(resetn), .FrameData_I(FrameData_I), .RowSelect(RowSelect),
      .FrameStrobe(FrameStrobe), .Commit(Commit),
`ifdef FRAME_DATA_REG_PARITY_EN
      .FrameParity_I(FrameParity_I), .ParityError(ParityError),
`endif
      .FrameData_O(FrameData_O), .RowLoaded(RowLoaded), .Filling(Filling),
      .CommitDone(CommitDone), .Overwrite(Overwrite), .FrameCount(FrameCount)
   );

   frame_data_reg_bank #(.AutoCommit(1'b1)) dut_ac (
      .CLK(CLK), .resetn(resetn), .FrameData_I(FrameData_I), .RowSelect(RowSelect),
      .FrameStrobe(FrameStrobe), .Commit(Commit),
`ifdef FRAME_DATA_REG_PARITY_EN
      .FrameParity_I(FrameParity_I), .ParityError(ac_ParityError),
`endif
      .FrameData_O(ac_FrameData_O), .RowLoaded(ac_RowLoaded), .Filling(ac_Filling),
      .CommitDone(ac_CommitDone), .Overwrite(ac_Overwrite), .FrameCount(ac_FrameCount)
   );

   task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [191:0] packed_rows();
      logic [191:0] v;
      for (int r = 0; r < 6; r++) v[r*32 +: 32] = exp_rows[r];
      return v;
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic write_row(input logic [4:0] sel, input logic [31:0] data);
      FrameStrobe = 1'b1;
      RowSelect   = sel;
      FrameData_I = data;
      tick();
      FrameStrobe = 1'b0;
      $display("write sel=%0d data=%08h RowLoaded=%b Filling=%b", sel, data, RowLoaded, Filling);
   endtask

   task automatic do_commit();
      Commit = 1'b1;
      tick();
      Commit = 1'b0;
      $display("commit CommitDone=%b FrameCount=%0d RowLoaded=%b", CommitDone, FrameCount, RowLoaded);
   endtask

   initial begin
      for (int r = 0; r < 6; r++) exp_rows[r] = '0;

      // Reset and idle
      tick();
      tick();
      resetn = 1'b1;
      chk("rst_data", FrameData_O, '0);
      chk("rst_loaded", {186'd0, RowLoaded}, '0);
      chk("rst_count", {184'd0, FrameCount}, '0);
      chk("rst_filling", {191'd0, Filling}, '0);
      chk("rst_overwrite", {191'd0, Overwrite}, '0);
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("idle_commitdone", {191'd0, CommitDone}, '0);
      end
      $display("idle 10 cycles FrameData_O=%0h FrameCount=%0d", FrameData_O, FrameCount);

      // Full frame load then commit
      for (int r = 0; r < 6; r++) begin
         write_row(5'(r + 1), 32'h11111111 * (r + 1));
         chk("load_loaded", {186'd0, RowLoaded}, {186'd0, 6'((1 << (r + 1)) - 1)});
         chk("load_filling", {191'd0, Filling}, 192'd1);
      end
      chk("load_active_unchanged", FrameData_O, '0);
      do_commit();
      for (int r = 0; r < 6; r++) exp_rows[r] = 32'h11111111 * (r + 1);
      chk("commit_data", FrameData_O, packed_rows());
      chk("commit_done", {191'd0, CommitDone}, 192'd1);
      chk("commit_count", {184'd0, FrameCount}, 192'd1);
      chk("commit_loaded", {186'd0, RowLoaded}, '0);
      chk("commit_idle", {191'd0, Filling}, '0);
      tick();
      chk("commit_done_pulse", {191'd0, CommitDone}, '0);

      // Out-of-range writes and commit in IDLE
      write_row(5'd0, 32'hDEADBEEF);
      chk("oor0_loaded", {186'd0, RowLoaded}, '0);
      write_row(5'd7, 32'hDEADBEEF);
      chk("oor7_loaded", {186'd0, RowLoaded}, '0);
      chk("oor_filling", {191'd0, Filling}, '0);
      do_commit();
      chk("idle_commit_count", {184'd0, FrameCount}, 192'd1);
      chk("idle_commit_done", {191'd0, CommitDone}, '0);
      chk("idle_commit_data", FrameData_O, packed_rows());

      // Overwrite of row 3
      write_row(5'd3, 32'hAAAA0000);
      chk("ow_first", {191'd0, Overwrite}, '0);
      write_row(5'd3, 32'h0000BBBB);
      chk("ow_second", {191'd0, Overwrite}, 192'd1);
      chk("ow_loaded", {186'd0, RowLoaded}, 192'h4);
      do_commit();
      exp_rows[2] = 32'h0000BBBB;
      chk("ow_commit_data", FrameData_O, packed_rows());
      chk("ow_commit_count", {184'd0, FrameCount}, 192'd2);

      // Write and commit on the same edge
      write_row(5'd5, 32'h5A5A5A5A);
      Commit = 1'b1;
      write_row(5'd1, 32'h01010101);
      Commit = 1'b0;
      exp_rows[4] = 32'h5A5A5A5A;
      chk("wc_data", FrameData_O, packed_rows());
      chk("wc_loaded", {186'd0, RowLoaded}, 192'h1);
      chk("wc_filling", {191'd0, Filling}, 192'd1);
      chk("wc_count", {184'd0, FrameCount}, 192'd3);
      chk("wc_done", {191'd0, CommitDone}, 192'd1);
      do_commit();
      exp_rows[0] = 32'h01010101;
      chk("wc_next_data", FrameData_O, packed_rows());
      chk("wc_next_count", {184'd0, FrameCount}, 192'd4);

`ifdef FRAME_DATA_REG_PARITY_EN
      // Bad-parity write is rejected
      write_row(5'd2, 32'h00000003);
      par_flip = 1'b1;
      write_row(5'd4, 32'h00000007);
      par_flip = 1'b0;
      chk("par_error", {191'd0, ParityError}, 192'd1);
      chk("par_loaded", {186'd0, RowLoaded}, 192'h2);
      do_commit();
      exp_rows[1] = 32'h00000003;
      chk("par_commit_data", FrameData_O, packed_rows());
`endif

      // Asynchronous reset in the middle of a fill
      write_row(5'd4, 32'hCCCCCCCC);
      chk("ar_filling", {191'd0, Filling}, 192'd1);
      #2;
      resetn = 1'b0;
      #1;
      chk("ar_data", FrameData_O, '0);
      chk("ar_loaded", {186'd0, RowLoaded}, '0);
      chk("ar_filling_clr", {191'd0, Filling}, '0);
      chk("ar_count", {184'd0, FrameCount}, '0);
      chk("ar_overwrite", {191'd0, Overwrite}, '0);
`ifdef FRAME_DATA_REG_PARITY_EN
      chk("ar_parity", {191'd0, ParityError}, '0);
`endif
      chk("ar_ac_data", ac_FrameData_O, '0);
      $display("async reset FrameData_O=%0h RowLoaded=%b", FrameData_O, RowLoaded);
      tick();
      tick();
      resetn = 1'b1;

      // AutoCommit instance: sixth load triggers commit on the next edge
      for (int r = 0; r < 6; r++) begin
         write_row(5'(r + 1), 32'hA0000000 + 32'(r));
         exp_rows[r] = 32'hA0000000 + 32'(r);
      end
      chk("ac_full_loaded", {186'd0, ac_RowLoaded}, 192'h3F);
      chk("ac_full_count", {184'd0, ac_FrameCount}, '0);
      write_row(5'd2, 32'h12345678);
      chk("ac_loaded", {186'd0, ac_RowLoaded}, 192'h2);
      chk("ac_count", {184'd0, ac_FrameCount}, 192'd1);
      chk("ac_done", {191'd0, ac_CommitDone}, 192'd1);
      chk("ac_data", ac_FrameData_O, packed_rows());
      chk("ac_filling", {191'd0, ac_Filling}, 192'd1);
      tick();
      chk("ac_no_recommit", {184'd0, ac_FrameCount}, 192'd1);
      chk("ac_done_pulse", {191'd0, ac_CommitDone}, '0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
